conv1_pixel_feeder: RTL and testbench
=====================================

Name: conv1_pixel_feeder

Overview:
- Source end of the conv layer 1 pixel stream.
- Holds one 28x28 8-bit image in an internal frame memory, loaded through a simple write port.
- On start, replays the frame in raster order as a pixel_out/valid_out stream, one pixel per cycle, driving conv layer 1's pixel_in/valid_in.
- Optional inter-row idle gaps; frame markers and completion status for the top-level controller.

Parameters:
- WIDTH, 28, pixels per row.
- HEIGHT, 28, rows per frame.
- PIX_W, 8, pixel width in bits.
- ROW_GAP, 0, idle (valid_out low) cycles inserted after each row except the last; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  frame-memory write strobe.
- wr_addr  input  10  write address, raster index row*WIDTH+col.
- wr_data  input  PIX_W  pixel written.
- start  input  1  begin streaming the stored frame; single-cycle pulse or level.
- pixel_out  output  PIX_W  streamed pixel; 0 whenever valid_out is low.
- valid_out  output  1  pixel_out valid this cycle.
- sof  output  1  high with the first pixel of the frame (row 0, col 0).
- eol  output  1  high with the last pixel of each row.
- eof  output  1  high with the last pixel of the frame.
- busy  output  1  stream in progress.
- done  output  1  one-cycle pulse after the last pixel.
- wr_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset:
  - All outputs 0; FSM to IDLE; row/col/gap counters cleared.
  - Frame memory contents are not reset.
  - Reset asserted mid-stream aborts immediately: no done pulse, and valid_out is low from the reset edge on.
- Frame memory:
  - WIDTH*HEIGHT entries, one write port, one synchronous read port (1-cycle read latency).
  - Write accepted when wr_en=1, busy=0 and wr_addr < WIDTH*HEIGHT.
  - Write rejected when busy=1 or wr_addr is out of range. A rejected write has no memory effect and wr_err pulses on the next cycle.
- FSM states: IDLE, STREAM, GAP, FLUSH.
  - IDLE: start=1 at edge T goes to STREAM. Read address 0 is issued in cycle T+1, busy=1 from T+1.
  - STREAM: one read address is issued per cycle, col increments.
    - At col=WIDTH-1 with row<HEIGHT-1: col goes to 0, row increments, then go to GAP if ROW_GAP>0, otherwise stay in STREAM.
    - At the last address (row=HEIGHT-1, col=WIDTH-1): go to FLUSH.
  - GAP: no reads for ROW_GAP cycles, then back to STREAM.
  - FLUSH: one cycle for the final read-data register, then IDLE.
- Output timing:
  - Output registers carry the address-phase flags through the read latency, so pixel_out, valid_out, sof, eol and eof are aligned and appear 1 cycle after their address is issued.
  - First valid pixel at cycle T+2.
  - Frame length is WIDTH*HEIGHT valid beats over WIDTH*HEIGHT + (HEIGHT-1)*ROW_GAP cycles.
- End of frame:
  - busy stays high through the cycle carrying eof.
  - done=1 in the cycle after eof, and busy=0 in that same cycle.
  - A new start is accepted in the done cycle or later.
- start while busy=1 is ignored; it is not queued.
- Write and start in the same IDLE cycle: the write is accepted and the stream reads the new value (write-first on the same edge).
- Address arithmetic: 10-bit raster address, formed as row*WIDTH+col or by an incrementing counter. The two forms must agree.

Test Plan:
- Load memory[i] = i mod 256 for all 784 entries, pulse start at T -> valid_out high for exactly 784 consecutive cycles from T+2. pixel_out sequence is 0,1,...,255,0,... ending at 783 mod 256 = 15. sof on beat 0; eol on beats 27, 55, ..., 783; eof on beat 783; done on the following cycle; busy=0 after.
- ROW_GAP=3, same image -> 784 valid beats over 784+27*3 = 865 cycles. Exactly 3 low valid_out cycles after each eol except the last; pixel_out=0 during gaps.
- During streaming, wr_en with wr_addr=5, wr_data=0xAA -> wr_err pulses. A second frame still outputs beat 5 = 5.
- In IDLE, wr_addr=800 -> wr_err pulses, no memory change. Repeat start pulses while busy -> frame length still 784 and exactly one done.
- Assert rst at beat 400 -> all outputs 0 the same cycle, no done. Deassert rst, then start -> full 784-beat frame with the original memory contents.
- start re-pulsed in the done cycle -> next frame's sof occurs 2 cycles later, with no missed or extra beats.

Source files
------------

// File: rtl/conv1_pixel_feeder.sv
// Frame-memory pixel source for conv layer 1: holds one image and replays it
// in raster order as an aligned pixel/valid stream with row and frame markers.
module conv1_pixel_feeder #(
   parameter int WIDTH   = 28,
   parameter int HEIGHT  = 28,
   parameter int PIX_W   = 8,
   parameter int ROW_GAP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [9:0]       wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             start,
   output logic [PIX_W-1:0] pixel_out,
   output logic             valid_out,
   output logic             sof,
   output logic             eol,
   output logic             eof,
   output logic             busy,
   output logic             done,
   output logic             wr_err
);

   localparam int DEPTH = WIDTH * HEIGHT;
   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
   localparam logic [3:0]       GAP_LOAD = (ROW_GAP > 0) ? 4'(ROW_GAP - 1) : 4'd0;
   localparam logic [9:0]       DEPTH_A  = 10'(DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, GAP, FLUSH} state_t;

   state_t           state, state_n;
   logic [COL_W-1:0] col, col_n;
   logic [ROW_W-1:0] row, row_n;
   logic [3:0]       gap_cnt, gap_n;
   logic [9:0]       rd_addr;
   logic             rd_en;
   logic             wr_ok;
   logic [PIX_W-1:0] mem [DEPTH];
   logic [PIX_W-1:0] rd_data;

   assign busy    = (state != IDLE);
   assign rd_en   = (state == STREAM);
   assign wr_ok   = wr_en && !busy && (wr_addr < DEPTH_A);
   assign rd_addr = 10'(row) * 10'(WIDTH) + 10'(col);

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      gap_n   = gap_cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = STREAM;
               col_n   = '0;
               row_n   = '0;
            end
         end
         STREAM: begin
            if (col == COL_LAST) begin
               if (row == ROW_LAST) begin
                  state_n = FLUSH;
               end else begin
                  col_n = '0;
                  row_n = row + 1'b1;
                  if (ROW_GAP > 0) begin
                     state_n = GAP;
                     gap_n   = GAP_LOAD;
                  end
               end
            end else begin
               col_n = col + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == '0) state_n = STREAM;
            else               gap_n   = gap_cnt - 1'b1;
         end
         FLUSH:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         col     <= '0;
         row     <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_n;
         col     <= col_n;
         row     <= row_n;
         gap_cnt <= gap_n;
      end
   end

   // NOTE: the frame store and its read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data      <= mem[rd_addr];
   end

   // Address-phase flags delayed by the read latency to line up with rd_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         eof       <= 1'b0;
         done      <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         valid_out <= rd_en;
         sof       <= rd_en && (row == '0) && (col == '0);
         eol       <= rd_en && (col == COL_LAST);
         eof       <= rd_en && (row == ROW_LAST) && (col == COL_LAST);
         done      <= (state == FLUSH);
         wr_err    <= wr_en && !wr_ok;
      end
   end

   assign pixel_out = valid_out ? rd_data : '0;

endmodule

// File: tb/tb_conv1_pixel_feeder.sv
// Directed bench for conv1_pixel_feeder: one instance without row gaps and
// one with ROW_GAP=3, checked beat by beat against a bench-side image copy.
module tb_conv1_pixel_feeder;

   localparam int W  = 28;
   localparam int H  = 28;
   localparam int N  = W * H;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en0, wr_en3, start0, start3;
   logic [9:0]    wr_addr;
   logic [PW-1:0] wr_data;

   logic [PW-1:0] pix0, pix3;
   logic valid0, sof0, eol0, eof0, busy0, done0, err0;
   logic valid3, sof3, eol3, eof3, busy3, done3, err3;

   logic [PW-1:0] exp_mem [N];
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  sel      = 1'b0;

   logic [PW-1:0] m_pix;
   logic m_valid, m_sof, m_eol, m_eof, m_busy, m_done, m_err;

   conv1_pixel_feeder #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ROW_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start0), .pixel_out(pix0), .valid_out(valid0), .sof(sof0), .eol(eol0),
      .eof(eof0), .busy(busy0), .done(done0), .wr_err(err0));

   conv1_pixel_feeder #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ROW_GAP(3)) dut3 (
      .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start3), .pixel_out(pix3), .valid_out(valid3), .sof(sof3), .eol(eol3),
      .eof(eof3), .busy(busy3), .done(done3), .wr_err(err3));

   always #5 clk = ~clk;

   always_comb begin
      m_pix   = sel ? pix3   : pix0;
      m_valid = sel ? valid3 : valid0;
      m_sof   = sel ? sof3   : sof0;
      m_eol   = sel ? eol3   : eol0;
      m_eof   = sel ? eof3   : eof0;
      m_busy  = sel ? busy3  : busy0;
      m_done  = sel ? done3  : done0;
      m_err   = sel ? err3   : err0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one frame on the selected instance and follows it to the done cycle.
   task automatic stream_frame(input bit gs, input int gap, input bit spam, input bit inj,
                               input string tag);
      int beat, cyc, lowrun, first_cyc, inj_state, exp_low;
      logic [PW+5:0] act, exp;
      beat = 0; cyc = 0; lowrun = 0; first_cyc = -1; inj_state = 0;
      sel = gs;
      if (gs) start3 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0; start3 = 1'b0; wr_en0 = 1'b0; wr_en3 = 1'b0;
      n_checks++;
      if (m_busy !== 1'b1 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s start_ack: busy=%b valid=%b, required busy=1 valid=0", tag, m_busy, m_valid);
      end
      while (beat < N && cyc < 2000) begin
         tick();
         cyc++;
         start0 = 1'b0;
         act = {m_pix, m_sof, m_eol, m_eof, m_busy, m_done, m_err};
         if (m_valid === 1'b1) begin
            if (first_cyc < 0) first_cyc = cyc;
            exp_low = (beat > 0 && beat % W == 0) ? gap : 0;
            n_checks++;
            if (lowrun != exp_low) begin
               n_fail++;
               $display("FAIL %s gap_len beat %0d: %0d idle cycles, required %0d", tag, beat, lowrun, exp_low);
            end
            exp = {exp_mem[beat], beat == 0, beat % W == W - 1, beat == N - 1, 1'b1, 1'b0, inj_state == 1};
            lowrun = 0;
            beat++;
         end else begin
            exp = {{PW{1'b0}}, 3'b000, 1'b1, 1'b0, inj_state == 1};
            lowrun++;
         end
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s beat %0d valid=%b {pix,sof,eol,eof,busy,done,err}: got %h, required %h",
                     tag, beat, m_valid, act, exp);
         end
         if (inj_state == 1) begin
            wr_en0 = 1'b0;
            inj_state = 2;
         end
         if (inj && inj_state == 0 && beat == 4) begin
            wr_en0 = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA;
            inj_state = 1;
         end
         if (spam && (beat == 100 || beat == 500)) start0 = 1'b1;
      end
      n_checks++;
      if (beat != N || first_cyc != 1 || cyc != N + (H - 1) * gap) begin
         n_fail++;
         $display("FAIL %s frame_shape: beats=%0d first=%0d cycles=%0d, required %0d/1/%0d",
                  tag, beat, first_cyc, cyc, N, N + (H - 1) * gap);
      end
      tick();
      n_checks++;
      if ({m_valid, m_done, m_busy, m_pix} !== {1'b0, 1'b1, 1'b0, {PW{1'b0}}}) begin
         n_fail++;
         $display("FAIL %s done_cycle: valid=%b done=%b busy=%b pix=%h, required 0/1/0/00",
                  tag, m_valid, m_done, m_busy, m_pix);
      end
   endtask

   task automatic check_quiet(input string tag);
      n_checks++;
      if ({m_valid, m_done, m_busy, m_sof, m_eol, m_eof, m_err, m_pix} !== '0) begin
         n_fail++;
         $display("FAIL %s quiet: valid=%b done=%b busy=%b sof=%b eol=%b eof=%b err=%b pix=%h, required all 0",
                  tag, m_valid, m_done, m_busy, m_sof, m_eol, m_eof, m_err, m_pix);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wr_en0 = 1'b0; wr_en3 = 1'b0; start0 = 1'b0; start3 = 1'b0;
      wr_addr = '0; wr_data = '0;
      tick(); tick();
      sel = 1'b0; check_quiet("reset_dut0");
      sel = 1'b1; check_quiet("reset_dut3");
      rst = 1'b0;
      tick();
      sel = 1'b0; check_quiet("after_reset");
   endtask

   task automatic test_load();
      int errs = 0;
      for (int i = 0; i < N; i++) begin
         wr_en0 = 1'b1; wr_en3 = 1'b1;
         wr_addr = 10'(i); wr_data = 8'(i % 256);
         exp_mem[i] = 8'(i % 256);
         tick();
         if (err0 !== 1'b0 || err3 !== 1'b0) errs++;
      end
      wr_en0 = 1'b0; wr_en3 = 1'b0;
      tick();
      n_checks++;
      if (errs != 0 || err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL load_wr_err: %0d rejected writes, required 0", errs);
      end
   endtask

   task automatic test_basic_frame();
      stream_frame(1'b0, 0, 1'b0, 1'b0, "basic");
      tick();
      check_quiet("basic_after_done");
   endtask

   task automatic test_row_gap();
      stream_frame(1'b1, 3, 1'b0, 1'b0, "row_gap");
      tick();
      check_quiet("row_gap_after_done");
      sel = 1'b0;
   endtask

   task automatic test_write_during_stream();
      stream_frame(1'b0, 0, 1'b0, 1'b1, "busy_write");
      stream_frame(1'b0, 0, 1'b0, 1'b0, "busy_write_replay");
      tick();
   endtask

   task automatic test_out_of_range_and_spam();
      wr_en0 = 1'b1; wr_addr = 10'd800; wr_data = 8'h77;
      tick();
      wr_en0 = 1'b0;
      n_checks++;
      if (err0 !== 1'b1) begin
         n_fail++;
         $display("FAIL oob_wr_err: wr_err=%b, required 1", err0);
      end
      tick();
      n_checks++;
      if (err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL oob_wr_err_pulse: wr_err=%b, required 0", err0);
      end
      stream_frame(1'b0, 0, 1'b1, 1'b0, "start_spam");
      for (int i = 0; i < 4; i++) begin
         tick();
         check_quiet("start_spam_single_done");
      end
   endtask

   task automatic test_reset_midstream();
      int beats = 0;
      int cyc = 0;
      sel = 1'b0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      while (beats <= 400 && cyc < 2000) begin
         tick();
         cyc++;
         if (valid0 === 1'b1) beats++;
      end
      n_checks++;
      if (beats != 401) begin
         n_fail++;
         $display("FAIL midstream_reach: %0d beats seen, required 401", beats);
      end
      #1 rst = 1'b1;
      #1 check_quiet("midstream_reset_edge");
      tick();
      check_quiet("midstream_reset_hold");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_quiet("midstream_no_done");
      end
      stream_frame(1'b0, 0, 1'b0, 1'b0, "after_reset_frame");
      tick();
   endtask

   task automatic test_back_to_back();
      stream_frame(1'b0, 0, 1'b0, 1'b0, "b2b_first");
      stream_frame(1'b0, 0, 1'b0, 1'b0, "b2b_second");
      tick();
      check_quiet("b2b_after_done");
   endtask

   task automatic test_write_start_same_cycle();
      wr_en0 = 1'b1; wr_addr = 10'd0; wr_data = 8'hC3;
      exp_mem[0] = 8'hC3;
      stream_frame(1'b0, 0, 1'b0, 1'b0, "write_and_start");
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_basic_frame();
      test_row_gap();
      test_write_during_stream();
      test_out_of_range_and_spam();
      test_reset_midstream();
      test_back_to_back();
      test_write_start_same_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
